// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the interrupt controller:
// FSM state encoding, default vector table placement and vector address helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE
  } irq_state_t;

  localparam logic [15:0] DEFAULT_VECTOR_BASE   = 16'hFF00;
  localparam logic [15:0] DEFAULT_VECTOR_STRIDE = 16'h0010;

  // Handler address of a source; the product and sum wrap at 16 bits.
  function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                              input logic [15:0] stride,
                                              input logic [15:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports whether any request is active and the
// index of the lowest-numbered active request.
module irq_priority_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    valid = 1'b0;
    index = '0;
    // Scan downward so the last hit, the lowest index, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered, maskable, fixed-priority interrupt controller with an
// IDLE/REQUEST/SERVICE handshake. Define IRQ_CONTROLLER_SYNC_EN for input synchronizers.
module irq_controller
  import cpu_pkg::*;
#(
  parameter int          NUM_SRC       = 8,
  parameter logic [15:0] VECTOR_BASE   = DEFAULT_VECTOR_BASE,
  parameter logic [15:0] VECTOR_STRIDE = DEFAULT_VECTOR_STRIDE
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         irq_src,
  input  logic                       mask_wr,
  input  logic [NUM_SRC-1:0]         mask_data,
  input  logic                       reset_irq,
  input  logic                       eoi,
  output logic                       irq,
  output logic [15:0]                irq_vector,
  output logic [$clog2(NUM_SRC)-1:0] irq_id,
  output logic [NUM_SRC-1:0]         pending,
  output logic [NUM_SRC-1:0]         mask
);

  localparam int ID_W = $clog2(NUM_SRC);

  irq_state_t         state;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;

`ifdef IRQ_CONTROLLER_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = irq_src;
`endif

  assign rise = src_s & ~src_prev;

  always_comb begin
    clr = '0;
    if (state == REQUEST && reset_irq) clr = NUM_SRC'(1) << irq_id;
  end

  irq_priority_encoder #(
    .N     (NUM_SRC),
    .IDX_W (ID_W)
  ) u_prio (
    .req   (pending & mask),
    .valid (win_valid),
    .index (win_id)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_prev <= '0;
      pending  <= '0;
      mask     <= '0;
    end else begin
      src_prev <= src_s;
      // A fresh edge beats a same-cycle acknowledge of the same bit.
      pending  <= (pending & ~clr) | rise;
      if (mask_wr) mask <= mask_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_id     <= '0;
      irq_vector <= VECTOR_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state      <= REQUEST;
            irq        <= 1'b1;
            irq_id     <= win_id;
            irq_vector <= vector_addr(VECTOR_BASE, VECTOR_STRIDE, 16'(win_id));
          end
        end
        REQUEST: begin
          // reset_irq takes precedence; a concurrent eoi is meaningless here.
          if (reset_irq) begin
            state <= SERVICE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues expected (id, vector)
// pairs, a negedge monitor checks them on each rising irq.
module tb_irq_controller;

`ifdef IRQ_CONTROLLER_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  irq_src;
  logic        mask_wr;
  logic [7:0]  mask_data;
  logic        reset_irq;
  logic        eoi;
  logic        irq;
  logic [15:0] irq_vector;
  logic [2:0]  irq_id;
  logic [7:0]  pending;
  logic [7:0]  mask;

  irq_controller #(.NUM_SRC(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_src    (irq_src),
    .mask_wr    (mask_wr),
    .mask_data  (mask_data),
    .reset_irq  (reset_irq),
    .eoi        (eoi),
    .irq        (irq),
    .irq_vector (irq_vector),
    .irq_id     (irq_id),
    .pending    (pending),
    .mask       (mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic irq_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] id, input logic [15:0] vec);
    exp_t e;
    e.id  = id;
    e.vec = vec;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [7:0] v);
    irq_src = v;
    tick(1);
    irq_src = '0;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_wr   = 1'b1;
    mask_data = v;
    tick(1);
    mask_wr   = 1'b0;
  endtask

  task automatic ack();
    reset_irq = 1'b1;
    tick(1);
    reset_irq = 1'b0;
  endtask

  task automatic end_irq();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  // Monitor: every rising irq must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && irq && !irq_q) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_unexpected: irq rose with id %0d, nothing expected", irq_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_id", 32'(irq_id), 32'(e.id));
        check("mon_vec", 32'(irq_vector), 32'(e.vec));
      end
    end
    irq_q <= reset ? 1'b0 : irq;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    irq_src   = '0;
    mask_wr   = 1'b0;
    mask_data = '0;
    reset_irq = 1'b0;
    eoi       = 1'b0;
    tick(2);
    check("rst_pending", 32'(pending), 32'h00);
    check("rst_mask", 32'(mask), 32'h00);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_id", 32'(irq_id), 32'h0);
    check("rst_vec", 32'(irq_vector), 32'hFF00);
    reset = 1'b0;

    // Single source 3 with all sources enabled.
    write_mask(8'hFF);
    check("s1_mask", 32'(mask), 32'hFF);
    push(3'd3, 16'hFF30);
    pulse(8'h08);
    tick(S);
    check("s1_pending", 32'(pending), 32'h08);
    check("s1_irq_lo", 32'(irq), 32'h0);
    tick(1);
    check("s1_irq_hi", 32'(irq), 32'h1);
    ack();
    check("s1_ack_irq", 32'(irq), 32'h0);
    check("s1_ack_pend", 32'(pending), 32'h00);
    end_irq();
    check("s1_eoi_irq", 32'(irq), 32'h0);

    // Sources 5 and 2 together: 2 first, then 5 back-to-back.
    push(3'd2, 16'hFF20);
    push(3'd5, 16'hFF50);
    pulse(8'h24);
    tick(S);
    check("s2_pending", 32'(pending), 32'h24);
    tick(1);
    check("s2_irq2", 32'(irq), 32'h1);
    ack();
    check("s2_pend_after_ack", 32'(pending), 32'h20);
    ack();
    check("s2_stray_ack_pend", 32'(pending), 32'h20);
    check("s2_stray_ack_irq", 32'(irq), 32'h0);
    end_irq();
    check("s2_idle_irq", 32'(irq), 32'h0);
    tick(1);
    check("s2_irq5", 32'(irq), 32'h1);
    // reset_irq and eoi together: must land in SERVICE, not IDLE.
    reset_irq = 1'b1;
    eoi       = 1'b1;
    tick(1);
    reset_irq = 1'b0;
    eoi       = 1'b0;
    check("s2_both_irq", 32'(irq), 32'h0);
    check("s2_both_pend", 32'(pending), 32'h00);
    pulse(8'h02);
    tick(S);
    check("s2_pend1", 32'(pending), 32'h02);
    tick(2);
    check("s2_service_holds", 32'(irq), 32'h0);
    push(3'd1, 16'hFF10);
    end_irq();
    check("s2_eoi_irq", 32'(irq), 32'h0);
    tick(1);
    check("s2_irq1", 32'(irq), 32'h1);
    ack();
    end_irq();

    // Masked source stays pending until enabled; mask change in REQUEST.
    write_mask(8'h00);
    push(3'd0, 16'hFF00);
    pulse(8'h01);
    tick(S);
    check("s3_pending", 32'(pending), 32'h01);
    tick(3);
    check("s3_masked_irq", 32'(irq), 32'h0);
    write_mask(8'h01);
    check("s3_unmask_irq_lo", 32'(irq), 32'h0);
    tick(1);
    check("s3_unmask_irq_hi", 32'(irq), 32'h1);
    write_mask(8'h00);
    check("s3_remask_mask", 32'(mask), 32'h00);
    check("s3_remask_irq", 32'(irq), 32'h1);
    check("s3_remask_id", 32'(irq_id), 32'h0);
    ack();
    check("s3_ack_pend", 32'(pending), 32'h00);
    check("s3_ack_irq", 32'(irq), 32'h0);
    end_irq();

    // New edge on the latched source coincides with reset_irq: set wins.
    write_mask(8'hFF);
    push(3'd6, 16'hFF60);
    pulse(8'h40);
    tick(S);
    tick(1);
    check("s4_irq", 32'(irq), 32'h1);
    irq_src = 8'h40;
    tick(S);
    reset_irq = 1'b1;
    tick(1);
    reset_irq = 1'b0;
    irq_src   = '0;
    check("s4_pend_kept", 32'(pending), 32'h40);
    check("s4_service", 32'(irq), 32'h0);
    push(3'd6, 16'hFF60);
    end_irq();
    check("s4_eoi_irq", 32'(irq), 32'h0);
    tick(1);
    check("s4_reassert", 32'(irq), 32'h1);
    ack();
    end_irq();

    // Reset during SERVICE with pending 0C discards everything.
    push(3'd2, 16'hFF20);
    pulse(8'h0C);
    tick(S);
    check("s5_pend0c", 32'(pending), 32'h0C);
    tick(1);
    check("s5_irq", 32'(irq), 32'h1);
    ack();
    check("s5_pend08", 32'(pending), 32'h08);
    pulse(8'h04);
    tick(S);
    check("s5_pend0c_svc", 32'(pending), 32'h0C);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("s5_rst_pend", 32'(pending), 32'h00);
    check("s5_rst_irq", 32'(irq), 32'h0);
    check("s5_rst_mask", 32'(mask), 32'h00);
    check("s5_rst_id", 32'(irq_id), 32'h0);
    check("s5_rst_vec", 32'(irq_vector), 32'hFF00);
    end_irq();
    check("s5_eoi_irq", 32'(irq), 32'h0);
    check("s5_eoi_pend", 32'(pending), 32'h00);
    write_mask(8'hFF);
    push(3'd7, 16'hFF70);
    pulse(8'h80);
    tick(S);
    tick(1);
    check("s5_idle_irq", 32'(irq), 32'h1);
    ack();
    end_irq();

    // Source held high through reset release: exactly one pending edge.
    irq_src = 8'h80;
    reset   = 1'b1;
    tick(2);
    reset   = 1'b0;
    check("s6_rst_pend", 32'(pending), 32'h00);
    tick(1 + S);
    check("s6_pend", 32'(pending), 32'h80);
    push(3'd7, 16'hFF70);
    write_mask(8'h80);
    tick(1);
    check("s6_irq", 32'(irq), 32'h1);
    ack();
    check("s6_ack_pend", 32'(pending), 32'h00);
    tick(3);
    check("s6_level_once", 32'(pending), 32'h00);
    irq_src = '0;
    end_irq();
    tick(2);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
